// File: rtl/operand2_decoder_pkg.sv
// Shared types for the operand-2 decoder: FSM states, shifter opcodes, operand modes.
package operand2_decoder_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned AMT_W   = 8;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned RADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RSRD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Encoding matches the Sh port of the external shifter.
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_e;

    typedef enum logic [1:0] {
        MODE_IMM    = 2'd0,
        MODE_IMM_SH = 2'd1,
        MODE_REG_SH = 2'd2
    } mode_e;

    // Classify a data-processing instruction by its operand-2 form.
    function automatic mode_e decode_mode(input logic [DATA_W-1:0] instr);
        mode_e m;
        if (instr[25]) begin
            m = MODE_IMM;
        end else if (instr[4]) begin
            m = MODE_REG_SH;
        end else begin
            m = MODE_IMM_SH;
        end
        return m;
    endfunction

endpackage

// File: rtl/operand2_decoder_if.sv
// Instruction, register-read, shifter and operand handshake signals of the decoder.
interface operand2_decoder_if;
    import operand2_decoder_pkg::*;

    logic                 InstrValid;
    logic                 InstrReady;
    logic [DATA_W-1:0]    Instr;
    logic [DATA_W-1:0]    RmData;
    logic                 CarryIn;

    logic                 RsRead;
    logic [RADDR_W-1:0]   RsAddr;
    logic [DATA_W-1:0]    RsData;

    logic [1:0]           Sh;
    logic [SHAMT_W-1:0]   Shamt5;
    logic [DATA_W-1:0]    ShIn;
    logic [DATA_W-1:0]    ShOut;

    logic                 OpValid;
    logic                 OpReady;
    logic [DATA_W-1:0]    Src2;
    logic                 ShCarry;

    // Environment side: issues instructions, serves the register file and shifter.
    modport master (
        output InstrValid, Instr, RmData, CarryIn, RsData, ShOut, OpReady,
        input  InstrReady, RsRead, RsAddr, Sh, Shamt5, ShIn, OpValid, Src2, ShCarry
    );

    // Decoder side.
    modport slave (
        input  InstrValid, Instr, RmData, CarryIn, RsData, ShOut, OpReady,
        output InstrReady, RsRead, RsAddr, Sh, Shamt5, ShIn, OpValid, Src2, ShCarry
    );

endinterface

// File: rtl/operand2_decoder_shift_fixup.sv
// Combinational special-case and carry-out resolution around the external shifter result.
module shift_fixup
    import operand2_decoder_pkg::*;
(
    input  mode_e              mode_i,
    input  sh_e                sh_i,
    input  logic [AMT_W-1:0]   amt8_i,
    input  logic [DATA_W-1:0]  rm_i,
    input  logic               cin_i,
    input  logic [DATA_W-1:0]  sh_out_i,
    output logic [DATA_W-1:0]  src2_c_o,
    output logic               carry_c_o
);

    logic [SHAMT_W-1:0] n;
    logic [SHAMT_W-1:0] lsl_idx;
    logic [SHAMT_W-1:0] rsh_idx;
    logic [DATA_W-1:0]  sign_fill;

    assign n         = amt8_i[SHAMT_W-1:0];
    assign lsl_idx   = SHAMT_W'(6'd32 - {1'b0, n});
    assign rsh_idx   = n - SHAMT_W'(1);
    assign sign_fill = {DATA_W{rm_i[DATA_W-1]}};

    // Pick shifter result or an override, and the matching carry-out.
    always_comb begin
        src2_c_o  = sh_out_i;
        carry_c_o = cin_i;
        case (mode_i)
            MODE_IMM: begin
                carry_c_o = (amt8_i == '0) ? cin_i : sh_out_i[DATA_W-1];
            end
            MODE_IMM_SH: begin
                if (n == '0) begin
                    case (sh_i)
                        SH_LSL: begin src2_c_o = rm_i;      carry_c_o = cin_i;           end
                        SH_LSR: begin src2_c_o = '0;        carry_c_o = rm_i[DATA_W-1];  end
                        SH_ASR: begin src2_c_o = sign_fill; carry_c_o = rm_i[DATA_W-1];  end
                        default: begin
                            src2_c_o  = {cin_i, rm_i[DATA_W-1:1]};
                            carry_c_o = rm_i[0];
                        end
                    endcase
                end else begin
                    case (sh_i)
                        SH_LSL:  carry_c_o = rm_i[lsl_idx];
                        SH_ROR:  carry_c_o = sh_out_i[DATA_W-1];
                        default: carry_c_o = rm_i[rsh_idx];
                    endcase
                end
            end
            MODE_REG_SH: begin
                if (amt8_i == '0) begin
                    src2_c_o  = rm_i;
                    carry_c_o = cin_i;
                end else if (sh_i == SH_ROR) begin
                    // Rotation by a multiple of 32 leaves the value unchanged.
                    if (n == '0) begin
                        src2_c_o  = rm_i;
                        carry_c_o = rm_i[DATA_W-1];
                    end else begin
                        carry_c_o = sh_out_i[DATA_W-1];
                    end
                end else if (amt8_i == AMT_W'(32)) begin
                    case (sh_i)
                        SH_LSL:  begin src2_c_o = '0;        carry_c_o = rm_i[0];         end
                        SH_LSR:  begin src2_c_o = '0;        carry_c_o = rm_i[DATA_W-1];  end
                        default: begin src2_c_o = sign_fill; carry_c_o = rm_i[DATA_W-1];  end
                    endcase
                end else if (amt8_i > AMT_W'(32)) begin
                    if (sh_i == SH_ASR) begin
                        src2_c_o  = sign_fill;
                        carry_c_o = rm_i[DATA_W-1];
                    end else begin
                        src2_c_o  = '0;
                        carry_c_o = 1'b0;
                    end
                end else if (sh_i == SH_LSL) begin
                    carry_c_o = rm_i[lsl_idx];
                end else begin
                    carry_c_o = rm_i[rsh_idx];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/operand2_decoder.sv
// Operand-2 decoder: captures an instruction, optionally reads Rs, drives the external
// shifter from registers, fixes up special cases and presents Src2/ShCarry by handshake.
module operand2_decoder
    import operand2_decoder_pkg::*;
(
    input  logic                CLK,
    input  logic                RESETn,
    operand2_decoder_if.slave   bus
);

    state_e               state_q;
    mode_e                mode_q;
    logic [DATA_W-1:0]    rm_q;
    logic                 cin_q;
    logic [AMT_W-1:0]     amt8_q;
    logic                 instr_ready_q;
    logic                 rs_read_q;
    logic [RADDR_W-1:0]   rs_addr_q;
    sh_e                  sh_q;
    logic [SHAMT_W-1:0]   shamt_q;
    logic [DATA_W-1:0]    shin_q;
    logic                 op_valid_q;
    logic [DATA_W-1:0]    src2_q;
    logic                 sh_carry_q;

    mode_e                in_mode;
    logic [DATA_W-1:0]    src2_d;
    logic                 sh_carry_d;

    assign in_mode = decode_mode(bus.Instr);

    shift_fixup u_fixup (
        .mode_i    (mode_q),
        .sh_i      (sh_q),
        .amt8_i    (amt8_q),
        .rm_i      (rm_q),
        .cin_i     (cin_q),
        .sh_out_i  (bus.ShOut),
        .src2_c_o  (src2_d),
        .carry_c_o (sh_carry_d)
    );

    // Sequencer: IDLE capture -> optional Rs read -> shift -> hold result until accepted.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_IMM;
            rm_q          <= '0;
            cin_q         <= 1'b0;
            amt8_q        <= '0;
            instr_ready_q <= 1'b0;
            rs_read_q     <= 1'b0;
            rs_addr_q     <= '0;
            sh_q          <= SH_LSL;
            shamt_q       <= '0;
            shin_q        <= '0;
            op_valid_q    <= 1'b0;
            src2_q        <= '0;
            sh_carry_q    <= 1'b0;
        end else begin
            rs_read_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    instr_ready_q <= 1'b1;
                    if (bus.InstrValid && instr_ready_q) begin
                        instr_ready_q <= 1'b0;
                        mode_q        <= in_mode;
                        rm_q          <= bus.RmData;
                        cin_q         <= bus.CarryIn;
                        if (in_mode == MODE_IMM) begin
                            sh_q    <= SH_ROR;
                            shin_q  <= DATA_W'(bus.Instr[7:0]);
                            shamt_q <= {bus.Instr[11:8], 1'b0};
                            amt8_q  <= AMT_W'({bus.Instr[11:8], 1'b0});
                        end else begin
                            sh_q    <= sh_e'(bus.Instr[6:5]);
                            shin_q  <= bus.RmData;
                            shamt_q <= (in_mode == MODE_REG_SH) ? '0 : bus.Instr[11:7];
                            amt8_q  <= AMT_W'(bus.Instr[11:7]);
                        end
                        if (in_mode == MODE_REG_SH) begin
                            rs_read_q <= 1'b1;
                            rs_addr_q <= bus.Instr[11:8];
                            state_q   <= ST_RSRD;
                        end else begin
                            state_q   <= ST_SHIFT;
                        end
                    end
                end
                ST_RSRD: begin
                    amt8_q  <= bus.RsData[AMT_W-1:0];
                    shamt_q <= bus.RsData[SHAMT_W-1:0];
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    src2_q     <= src2_d;
                    sh_carry_q <= sh_carry_d;
                    op_valid_q <= 1'b1;
                    state_q    <= ST_OUT;
                end
                default: begin
                    if (bus.OpReady) begin
                        op_valid_q    <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.InstrReady = instr_ready_q;
    assign bus.RsRead     = rs_read_q;
    assign bus.RsAddr     = rs_addr_q;
    assign bus.Sh         = sh_q;
    assign bus.Shamt5     = shamt_q;
    assign bus.ShIn       = shin_q;
    assign bus.OpValid    = op_valid_q;
    assign bus.Src2       = src2_q;
    assign bus.ShCarry    = sh_carry_q;

endmodule

// File: tb/tb_operand2_decoder.sv
// Directed bench for operand2_decoder with a behavioural shifter and register-file port.
module tb_operand2_decoder;

    logic CLK;
    logic RESETn;

    operand2_decoder_if bus ();

    operand2_decoder dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rd_total = 0;
    int ov_total = 0;
    logic [3:0]  rd_addr_seen = '0;
    logic [31:0] rs_val = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference barrel shifter standing in for the external combinational unit.
    function automatic logic [31:0] shift_model(input logic [1:0] sh, input logic [4:0] s,
                                                input logic [31:0] x);
        logic [31:0] r;
        case (sh)
            2'b00:   r = x << s;
            2'b01:   r = x >> s;
            2'b10:   r = 32'($signed(x) >>> s);
            default: r = (x >> s) | (x << (6'd32 - {1'b0, s}));
        endcase
        return r;
    endfunction

    assign bus.ShOut  = shift_model(bus.Sh, bus.Shamt5, bus.ShIn);
    assign bus.RsData = bus.RsRead ? rs_val : 32'hDEAD_BEEF;

    // Count Rs reads and OpValid cycles.
    always @(posedge CLK) begin
        if (bus.RsRead) begin
            rd_total     <= rd_total + 1;
            rd_addr_seen <= bus.RsAddr;
        end
        if (bus.OpValid) ov_total <= ov_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one instruction and check result, latency and Rs-read behaviour.
    task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] rm,
                          input logic cin, input logic [31:0] rs,
                          input logic [31:0] exp_src2, input logic exp_c,
                          input int exp_lat, input int exp_rd);
        int n;
        int rd_base;
        @(negedge CLK);
        rs_val         = rs;
        rd_base        = rd_total;
        bus.Instr      = instr;
        bus.RmData     = rm;
        bus.CarryIn    = cin;
        bus.InstrValid = 1'b1;
        bus.OpReady    = 1'b1;
        check({tag, "_rdy"}, 32'(bus.InstrReady), 32'd1);
        @(posedge CLK); #1;
        bus.InstrValid = 1'b0;
        bus.Instr      = '0;
        bus.RmData     = ~rm;
        bus.CarryIn    = ~cin;
        n = 1;
        while (!bus.OpValid && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_src2"}, bus.Src2, exp_src2);
        check({tag, "_c"}, 32'(bus.ShCarry), 32'(exp_c));
        check({tag, "_rdcnt"}, 32'(rd_total - rd_base), 32'(exp_rd));
        if (exp_rd != 0) check({tag, "_rsaddr"}, 32'(rd_addr_seen), 32'(instr[11:8]));
        @(posedge CLK); #1;
        check({tag, "_done"}, {30'd0, bus.OpValid, bus.InstrReady}, 32'b01);
    endtask

    initial begin
        int ov_base;
        RESETn         = 1'b0;
        bus.InstrValid = 1'b0;
        bus.Instr      = '0;
        bus.RmData     = '0;
        bus.CarryIn    = 1'b0;
        bus.OpReady    = 1'b0;
        #12;
        check("rst_rdy", 32'(bus.InstrReady), 32'd0);
        check("rst_ov", 32'(bus.OpValid), 32'd0);
        check("rst_src2", bus.Src2, 32'd0);
        check("rst_misc", {bus.ShCarry, bus.RsRead, bus.RsAddr, bus.Sh, bus.Shamt5}, 32'd0);
        check("rst_shin", bus.ShIn, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_rdy", 32'(bus.InstrReady), 32'd1);

        // Immediate forms
        run_op("imm_rot1",  32'h0200_01FF, 32'h1111_1111, 1'b0, 32'h0, 32'hC000_003F, 1'b1, 2, 0);
        run_op("imm_rot0",  32'h0200_0055, 32'h0,         1'b1, 32'h0, 32'h0000_0055, 1'b1, 2, 0);
        // Immediate-shift forms
        run_op("lsr0",      32'h0000_0020, 32'h8000_0001, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 2, 0);
        run_op("rrx",       32'h0000_0060, 32'h0000_0003, 1'b1, 32'h0, 32'h8000_0001, 1'b1, 2, 0);
        run_op("lsl4",      32'h0000_0200, 32'hF000_000F, 1'b0, 32'h0, 32'h0000_00F0, 1'b1, 2, 0);
        run_op("asr1",      32'h0000_00C0, 32'h8000_0001, 1'b0, 32'h0, 32'hC000_0000, 1'b1, 2, 0);
        run_op("ror8",      32'h0000_0460, 32'h0000_00A5, 1'b0, 32'h0, 32'hA500_0000, 1'b1, 2, 0);
        // Register-shift forms
        run_op("rlsl32",    32'h0000_0210, 32'h0000_0001, 1'b0, 32'h20,  32'h0000_0000, 1'b1, 3, 1);
        run_op("rasr64",    32'h0000_0350, 32'h8000_0000, 1'b0, 32'h40,  32'hFFFF_FFFF, 1'b1, 3, 1);
        run_op("rror32",    32'h0000_0470, 32'h8000_0000, 1'b0, 32'h20,  32'h8000_0000, 1'b1, 3, 1);
        run_op("rlsr4",     32'h0000_0530, 32'h0000_00F8, 1'b0, 32'h04,  32'h0000_000F, 1'b1, 3, 1);
        run_op("rlsl0",     32'h0000_0610, 32'h0000_1234, 1'b1, 32'h00,  32'h0000_1234, 1'b1, 3, 1);
        run_op("rlsr33",    32'h0000_0730, 32'hFFFF_FFFF, 1'b1, 32'h21,  32'h0000_0000, 1'b0, 3, 1);
        run_op("rlsl256",   32'h0000_0810, 32'h0000_ABCD, 1'b0, 32'h100, 32'h0000_ABCD, 1'b0, 3, 1);

        // Back-pressure: result held, second instruction ignored
        @(negedge CLK);
        bus.Instr = 32'h0200_01FF; bus.RmData = '0; bus.CarryIn = 1'b0;
        bus.InstrValid = 1'b1; bus.OpReady = 1'b0;
        @(posedge CLK); #1;
        bus.InstrValid = 1'b0;
        @(posedge CLK); #1;
        check("bp_ov_first", 32'(bus.OpValid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bus.Instr = 32'h0200_0055; bus.CarryIn = 1'b1; bus.InstrValid = 1'b1;
            @(posedge CLK); #1;
            check("bp_hold_ov", 32'(bus.OpValid), 32'd1);
            check("bp_hold_src2", bus.Src2, 32'hC000_003F);
            check("bp_hold_c", 32'(bus.ShCarry), 32'd1);
            check("bp_hold_rdy", 32'(bus.InstrReady), 32'd0);
        end
        @(negedge CLK);
        bus.InstrValid = 1'b0; bus.OpReady = 1'b1;
        ov_base = ov_total;
        @(posedge CLK); #1;
        check("bp_release", {30'd0, bus.OpValid, bus.InstrReady}, 32'b01);
        repeat (4) @(posedge CLK);
        #1;
        check("bp_no_second", 32'(ov_total - ov_base), 32'd1);

        // Reset during the Rs read discards the instruction
        @(negedge CLK);
        rs_val = 32'h20;
        bus.Instr = 32'h0000_0210; bus.RmData = 32'h1; bus.InstrValid = 1'b1;
        @(posedge CLK); #1;
        bus.InstrValid = 1'b0;
        check("mid_rsrd", 32'(bus.RsRead), 32'd1);
        ov_base = ov_total;
        #1 RESETn = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(bus.InstrReady), 32'd0);
        check("mid_rst_misc", {bus.OpValid, bus.ShCarry, bus.RsRead, bus.RsAddr, bus.Sh, bus.Shamt5},
              32'd0);
        check("mid_rst_data", bus.Src2 | bus.ShIn, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;
        check("mid_idle", 32'(bus.InstrReady), 32'd1);
        repeat (6) @(posedge CLK);
        #1;
        check("mid_no_ov", 32'(ov_total - ov_base), 32'd0);

        run_op("after_rst", 32'h0200_01FF, 32'h0, 1'b0, 32'h0, 32'hC000_003F, 1'b1, 2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
